control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 No parameters; all widths fixed by the 8-bit datapath.
REQ-002 clk  in  1  single system clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 instruction  in  8  IR contents; [7:4] opcode, [3:2] src register, [1:0] dest register.
REQ-005 Zflag  in  1  registered ALU zero flag from the datapath.
REQ-006 Sel_Bus_1_Mux  out  3  Bus_1 source select: 0=R0, 1=R1, 2=R2, 3=R3, 4=PC.
REQ-007 Sel_Bus_2_Mux  out  2  Bus_2 source select: 0=ALU, 1=Bus_1, 2=mem_word.
REQ-008 Load_R0, Load_R1, Load_R2, Load_R3  out  1 each  register-file load strobes.
REQ-009 Load_PC  out  1  load PC from Bus_2.
REQ-010 Inc_PC  out  1  increment PC.
REQ-011 Load_IR  out  1  load IR from Bus_2.
REQ-012 Load_Add_R  out  1  load address register from Bus_2.
REQ-013 Load_Reg_Y  out  1  load ALU operand Y from Bus_2.
REQ-014 Load_Reg_Z  out  1  capture ALU zero flag.
REQ-015 write  out  1  memory write strobe; data is Bus_1, address is Add_R.
REQ-016 halted  out  1  high while FSM is in S_HALT.

Function
REQ-017 Opcodes SHALL be NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8, HALT=15; 9-14 illegal.
REQ-018 FSM states SHALL be S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1, S_RD1, S_RD2, S_WR1, S_WR2, S_BR1, S_BR2, S_HALT, 4-bit registered state.
REQ-019 Outputs SHALL be combinational from state, instruction and Zflag; any strobe not listed for a state is 0, unlisted selects are 0.
REQ-020 S_IDLE: no strobes; next S_FET1.
REQ-021 S_FET1: Sel1=PC, Sel2=Bus_1, Load_Add_R; next S_FET2.
REQ-022 S_FET2: Sel2=mem, Load_IR, Inc_PC; next S_DEC.
REQ-023 S_DEC, NOP: no strobes; next S_FET1.
REQ-024 S_DEC, ADD/SUB/AND: Sel1=src, Sel2=Bus_1, Load_Reg_Y; next S_EX1.
REQ-025 S_EX1: Sel1=dest, Sel2=ALU, Load_Reg_Z, Load_R[dest]; next S_FET1.
REQ-026 S_DEC, NOT: Sel1=src, Sel2=ALU, Load_Reg_Z, Load_R[dest]; next S_FET1.
REQ-027 S_DEC, RD/WR/BR, and BRZ with Zflag=1: Sel1=PC, Sel2=Bus_1, Load_Add_R; next S_RD1/S_WR1/S_BR1 respectively (BRZ to S_BR1).
REQ-028 S_DEC, BRZ with Zflag=0: Inc_PC only (skip operand byte); next S_FET1.
REQ-029 S_RD1 and S_WR1: Sel2=mem, Load_Add_R, Inc_PC; next S_RD2/S_WR2.
REQ-030 S_RD2: Sel2=mem, Load_R[dest]; next S_FET1.
REQ-031 S_WR2: Sel1=src, write=1; next S_FET1.
REQ-032 S_BR1: Sel2=mem, Load_Add_R; next S_BR2.
REQ-033 S_BR2: Sel2=mem, Load_PC; Inc_PC SHALL NOT assert; next S_FET1.
REQ-034 S_DEC, HALT: no strobes; next S_HALT; S_HALT holds with no strobes and halted=1 until rst.
REQ-035 At most one Load_Rn SHALL assert in any cycle; Load_PC and Inc_PC SHALL never assert together.
REQ-036 Zflag SHALL be sampled only in S_DEC.

Reset
REQ-037 rst=1 at a rising edge SHALL force state to S_IDLE from any state, including mid-instruction and S_HALT; all strobes 0, selects 0, halted 0 during and after reset until S_FET1.
REQ-038 First fetch (S_FET1) SHALL occur on the second rising edge after rst deasserts.

Configuration
REQ-039 Macro CU_ILLEGAL_HALT_EN: defined, opcodes 9-14 in S_DEC go to S_HALT (halted=1); undefined, they behave exactly as NOP.

Structure
REQ-040 Shared package risc_spm_pkg SHALL hold opcode constants, state enumeration, and Sel_Bus_1/Sel_Bus_2 encodings, reused by the datapath muxes.
REQ-041 Single module, no sub-module; next-state and output decode in one combinational block, state in one registered block.

Verification
REQ-042 Reset, then instruction=0x00 -> S_FET1 strobes (Sel1=4, Sel2=1, Load_Add_R) then S_FET2 (Sel2=2, Load_IR, Inc_PC), NOP returns to S_FET1 after 3 cycles.
REQ-043 instruction=0x16 (ADD R1->R2) -> S_DEC Sel1=1, Load_Reg_Y; S_EX1 Sel1=2, Sel2=0, Load_R2, Load_Reg_Z; 4-cycle instruction.
REQ-044 instruction=0x83, Zflag=0 -> S_DEC Inc_PC only, next S_FET1; Zflag=1 -> S_BR1 then S_BR2 with Load_PC=1, Inc_PC=0.
REQ-045 instruction=0x6C (WR R3) -> S_WR2 write=1, Sel1=3; instruction=0x51 (RD R1) -> S_RD2 Load_R1, Sel2=2.
REQ-046 instruction=0xF0 -> halted=1 held 10 cycles, no strobes; rst pulse -> S_IDLE; instruction=0x90 -> S_HALT with CU_ILLEGAL_HALT_EN, NOP without; rst asserted in S_RD1 -> S_IDLE next edge, no Load_R strobe.

Source files
------------

// File: rtl/risc_spm_pkg.sv
// Shared RISC-SPM definitions: opcodes, control-FSM states and bus-mux select encodings.
// Used by the control unit and by the datapath muxes.
package risc_spm_pkg;

  localparam int unsigned WORD_W  = 8;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned SEL1_W  = 3;
  localparam int unsigned SEL2_W  = 2;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'd1;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'd2;
  localparam logic [OPC_W-1:0] OP_AND  = 4'd3;
  localparam logic [OPC_W-1:0] OP_NOT  = 4'd4;
  localparam logic [OPC_W-1:0] OP_RD   = 4'd5;
  localparam logic [OPC_W-1:0] OP_WR   = 4'd6;
  localparam logic [OPC_W-1:0] OP_BR   = 4'd7;
  localparam logic [OPC_W-1:0] OP_BRZ  = 4'd8;
  localparam logic [OPC_W-1:0] OP_HALT = 4'd15;

  localparam logic [STATE_W-1:0] S_IDLE = 4'd0;
  localparam logic [STATE_W-1:0] S_FET1 = 4'd1;
  localparam logic [STATE_W-1:0] S_FET2 = 4'd2;
  localparam logic [STATE_W-1:0] S_DEC  = 4'd3;
  localparam logic [STATE_W-1:0] S_EX1  = 4'd4;
  localparam logic [STATE_W-1:0] S_RD1  = 4'd5;
  localparam logic [STATE_W-1:0] S_RD2  = 4'd6;
  localparam logic [STATE_W-1:0] S_WR1  = 4'd7;
  localparam logic [STATE_W-1:0] S_WR2  = 4'd8;
  localparam logic [STATE_W-1:0] S_BR1  = 4'd9;
  localparam logic [STATE_W-1:0] S_BR2  = 4'd10;
  localparam logic [STATE_W-1:0] S_HALT = 4'd11;

  localparam logic [SEL1_W-1:0] SEL1_R0 = 3'd0;
  localparam logic [SEL1_W-1:0] SEL1_R1 = 3'd1;
  localparam logic [SEL1_W-1:0] SEL1_R2 = 3'd2;
  localparam logic [SEL1_W-1:0] SEL1_R3 = 3'd3;
  localparam logic [SEL1_W-1:0] SEL1_PC = 3'd4;

  localparam logic [SEL2_W-1:0] SEL2_ALU  = 2'd0;
  localparam logic [SEL2_W-1:0] SEL2_BUS1 = 2'd1;
  localparam logic [SEL2_W-1:0] SEL2_MEM  = 2'd2;

  // Register-file index to its Bus_1 select code.
  function automatic logic [SEL1_W-1:0] sel1_reg(input logic [1:0] r);
    return {1'b0, r};
  endfunction

  // Register-file index to one-hot load strobes (bit n loads Rn).
  function automatic logic [3:0] reg_onehot(input logic [1:0] r);
    return 4'b0001 << r;
  endfunction

endpackage

// File: rtl/control_unit.sv
// RISC-SPM control unit: 4-bit state FSM with combinational strobe/select decode.
// Optional CU_ILLEGAL_HALT_EN: opcodes 9-14 halt the machine instead of acting as NOP.
module control_unit
  import risc_spm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] instruction,
  input  logic              Zflag,
  output logic [SEL1_W-1:0] Sel_Bus_1_Mux,
  output logic [SEL2_W-1:0] Sel_Bus_2_Mux,
  output logic              Load_R0,
  output logic              Load_R1,
  output logic              Load_R2,
  output logic              Load_R3,
  output logic              Load_PC,
  output logic              Inc_PC,
  output logic              Load_IR,
  output logic              Load_Add_R,
  output logic              Load_Reg_Y,
  output logic              Load_Reg_Z,
  output logic              write,
  output logic              halted
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  logic [OPC_W-1:0]  opcode;
  logic [1:0]        src;
  logic [1:0]        dest;

  logic [SEL1_W-1:0] sel1_c;
  logic [SEL2_W-1:0] sel2_c;
  logic [3:0]        load_r_c;
  logic              load_pc_c;
  logic              inc_pc_c;
  logic              load_ir_c;
  logic              load_add_r_c;
  logic              load_reg_y_c;
  logic              load_reg_z_c;
  logic              write_c;
  logic              halted_c;

  assign opcode = instruction[7:4];
  assign src    = instruction[3:2];
  assign dest   = instruction[1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and control decode; everything is held quiet while rst is high.
  always_comb begin
    state_d      = state_q;
    sel1_c       = SEL1_R0;
    sel2_c       = SEL2_ALU;
    load_r_c     = 4'b0000;
    load_pc_c    = 1'b0;
    inc_pc_c     = 1'b0;
    load_ir_c    = 1'b0;
    load_add_r_c = 1'b0;
    load_reg_y_c = 1'b0;
    load_reg_z_c = 1'b0;
    write_c      = 1'b0;
    halted_c     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: state_d = S_FET1;
        S_FET1: begin
          sel1_c       = SEL1_PC;
          sel2_c       = SEL2_BUS1;
          load_add_r_c = 1'b1;
          state_d      = S_FET2;
        end
        S_FET2: begin
          sel2_c    = SEL2_MEM;
          load_ir_c = 1'b1;
          inc_pc_c  = 1'b1;
          state_d   = S_DEC;
        end
        S_DEC: begin
          case (opcode)
            OP_NOP: state_d = S_FET1;
            OP_ADD, OP_SUB, OP_AND: begin
              sel1_c       = sel1_reg(src);
              sel2_c       = SEL2_BUS1;
              load_reg_y_c = 1'b1;
              state_d      = S_EX1;
            end
            OP_NOT: begin
              sel1_c       = sel1_reg(src);
              sel2_c       = SEL2_ALU;
              load_reg_z_c = 1'b1;
              load_r_c     = reg_onehot(dest);
              state_d      = S_FET1;
            end
            OP_RD, OP_WR, OP_BR: begin
              sel1_c       = SEL1_PC;
              sel2_c       = SEL2_BUS1;
              load_add_r_c = 1'b1;
              state_d      = (opcode == OP_RD) ? S_RD1 :
                             (opcode == OP_WR) ? S_WR1 : S_BR1;
            end
            OP_BRZ: begin
              if (Zflag) begin
                sel1_c       = SEL1_PC;
                sel2_c       = SEL2_BUS1;
                load_add_r_c = 1'b1;
                state_d      = S_BR1;
              end else begin
                // Not taken: step the PC over the branch-target byte.
                inc_pc_c = 1'b1;
                state_d  = S_FET1;
              end
            end
            OP_HALT: state_d = S_HALT;
            default: begin
`ifdef CU_ILLEGAL_HALT_EN
              state_d = S_HALT;
`else
              state_d = S_FET1;
`endif
            end
          endcase
        end
        S_EX1: begin
          sel1_c       = sel1_reg(dest);
          sel2_c       = SEL2_ALU;
          load_reg_z_c = 1'b1;
          load_r_c     = reg_onehot(dest);
          state_d      = S_FET1;
        end
        S_RD1, S_WR1: begin
          sel2_c       = SEL2_MEM;
          load_add_r_c = 1'b1;
          inc_pc_c     = 1'b1;
          state_d      = (state_q == S_RD1) ? S_RD2 : S_WR2;
        end
        S_RD2: begin
          sel2_c   = SEL2_MEM;
          load_r_c = reg_onehot(dest);
          state_d  = S_FET1;
        end
        S_WR2: begin
          sel1_c  = sel1_reg(src);
          write_c = 1'b1;
          state_d = S_FET1;
        end
        S_BR1: begin
          sel2_c       = SEL2_MEM;
          load_add_r_c = 1'b1;
          state_d      = S_BR2;
        end
        S_BR2: begin
          sel2_c    = SEL2_MEM;
          load_pc_c = 1'b1;
          state_d   = S_FET1;
        end
        S_HALT: begin
          halted_c = 1'b1;
          state_d  = S_HALT;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign Sel_Bus_1_Mux = sel1_c;
  assign Sel_Bus_2_Mux = sel2_c;
  assign Load_R0       = load_r_c[0];
  assign Load_R1       = load_r_c[1];
  assign Load_R2       = load_r_c[2];
  assign Load_R3       = load_r_c[3];
  assign Load_PC       = load_pc_c;
  assign Inc_PC        = inc_pc_c;
  assign Load_IR       = load_ir_c;
  assign Load_Add_R    = load_add_r_c;
  assign Load_Reg_Y    = load_reg_y_c;
  assign Load_Reg_Z    = load_reg_z_c;
  assign write         = write_c;
  assign halted        = halted_c;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: hand-written instruction sequences, then random instruction
// streams with random resets checked against an instruction-level micro-op model.
module tb_control_unit;

  typedef struct packed {
    logic [2:0] s1;
    logic [1:0] s2;
    logic [3:0] ld_r;   // bit n = Load_Rn
    logic [7:0] f;      // {Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write, halted}
  } exp_t;

  typedef struct packed {
    logic [7:0] ins;
    logic       z;
    exp_t       e;
    logic       hlt_next;
  } step_t;

  localparam logic [7:0] F_PC  = 8'h80;
  localparam logic [7:0] F_INC = 8'h40;
  localparam logic [7:0] F_IR  = 8'h20;
  localparam logic [7:0] F_AR  = 8'h10;
  localparam logic [7:0] F_Y   = 8'h08;
  localparam logic [7:0] F_Z   = 8'h04;
  localparam logic [7:0] F_WR  = 8'h02;
  localparam logic [7:0] F_H   = 8'h01;

  logic       clk;
  logic       rst;
  logic [7:0] instruction;
  logic       Zflag;
  logic [2:0] Sel_Bus_1_Mux;
  logic [1:0] Sel_Bus_2_Mux;
  logic       Load_R0, Load_R1, Load_R2, Load_R3;
  logic       Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z;
  logic       write, halted;

  int checks;
  int errors;
  step_t q[$];
  logic halted_m;

  control_unit dut (
    .clk(clk), .rst(rst), .instruction(instruction), .Zflag(Zflag),
    .Sel_Bus_1_Mux(Sel_Bus_1_Mux), .Sel_Bus_2_Mux(Sel_Bus_2_Mux),
    .Load_R0(Load_R0), .Load_R1(Load_R1), .Load_R2(Load_R2), .Load_R3(Load_R3),
    .Load_PC(Load_PC), .Inc_PC(Inc_PC), .Load_IR(Load_IR), .Load_Add_R(Load_Add_R),
    .Load_Reg_Y(Load_Reg_Y), .Load_Reg_Z(Load_Reg_Z), .write(write), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] s1, input logic [1:0] s2,
                              input logic [3:0] ldr, input logic [7:0] f);
    exp_t e;
    e.s1 = s1; e.s2 = s2; e.ld_r = ldr; e.f = f;
    return e;
  endfunction

  localparam exp_t EZ = '0;
  exp_t e_f1, e_f2, e_h;

  // Drive one cycle of inputs, compare all outputs mid-cycle, advance past the edge.
  task automatic cyc(input logic r, input logic [7:0] ins, input logic z,
                     input exp_t e, input string nm);
    exp_t act;
    rst = r; instruction = ins; Zflag = z;
    @(negedge clk);
    act = {Sel_Bus_1_Mux, Sel_Bus_2_Mux, {Load_R3, Load_R2, Load_R1, Load_R0},
           {Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write, halted}};
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string nm);
    cyc(1'b0, 8'($urandom), 1'($urandom), e_f1, {nm, "_fet1"});
    cyc(1'b0, 8'($urandom), 1'($urandom), e_f2, {nm, "_fet2"});
  endtask

  function automatic step_t mkstep(input logic [7:0] ins, input logic z,
                                   input exp_t e, input logic h);
    step_t s;
    s.ins = ins; s.z = z; s.e = e; s.hlt_next = h;
    return s;
  endfunction

  // Reference model: expand one whole instruction into its expected per-cycle outputs.
  task automatic plan();
    logic [7:0] ins;
    logic [3:0] op;
    logic [2:0] src, dst;
    logic [3:0] oh;
    logic       zd;
    ins = 8'($urandom);
    op  = ins[7:4];
    src = {1'b0, ins[3:2]};
    dst = {1'b0, ins[1:0]};
    oh  = 4'b0001 << ins[1:0];
    zd  = 1'($urandom);
    q.push_back(mkstep(8'($urandom), 1'($urandom), e_f1, 1'b0));
    q.push_back(mkstep(8'($urandom), 1'($urandom), e_f2, 1'b0));
    case (op)
      4'd0: q.push_back(mkstep(ins, zd, EZ, 1'b0));
      4'd1, 4'd2, 4'd3: begin
        q.push_back(mkstep(ins, zd, mk(src, 2'd1, 4'd0, F_Y), 1'b0));
        q.push_back(mkstep(ins, 1'($urandom), mk(dst, 2'd0, oh, F_Z), 1'b0));
      end
      4'd4: q.push_back(mkstep(ins, zd, mk(src, 2'd0, oh, F_Z), 1'b0));
      4'd5: begin
        q.push_back(mkstep(ins, zd, mk(3'd4, 2'd1, 4'd0, F_AR), 1'b0));
        q.push_back(mkstep(ins, 1'($urandom), mk(3'd0, 2'd2, 4'd0, F_AR | F_INC), 1'b0));
        q.push_back(mkstep(ins, 1'($urandom), mk(3'd0, 2'd2, oh, 8'h00), 1'b0));
      end
      4'd6: begin
        q.push_back(mkstep(ins, zd, mk(3'd4, 2'd1, 4'd0, F_AR), 1'b0));
        q.push_back(mkstep(ins, 1'($urandom), mk(3'd0, 2'd2, 4'd0, F_AR | F_INC), 1'b0));
        q.push_back(mkstep(ins, 1'($urandom), mk(src, 2'd0, 4'd0, F_WR), 1'b0));
      end
      4'd7, 4'd8: begin
        if (op == 4'd8 && !zd) begin
          q.push_back(mkstep(ins, zd, mk(3'd0, 2'd0, 4'd0, F_INC), 1'b0));
        end else begin
          q.push_back(mkstep(ins, zd, mk(3'd4, 2'd1, 4'd0, F_AR), 1'b0));
          q.push_back(mkstep(ins, 1'($urandom), mk(3'd0, 2'd2, 4'd0, F_AR), 1'b0));
          q.push_back(mkstep(ins, 1'($urandom), mk(3'd0, 2'd2, 4'd0, F_PC), 1'b0));
        end
      end
      4'd15: q.push_back(mkstep(ins, zd, EZ, 1'b1));
      default: begin
`ifdef CU_ILLEGAL_HALT_EN
        q.push_back(mkstep(ins, zd, EZ, 1'b1));
`else
        q.push_back(mkstep(ins, zd, EZ, 1'b0));
`endif
      end
    endcase
  endtask

  initial begin
    checks = 0; errors = 0;
    e_f1 = mk(3'd4, 2'd1, 4'd0, F_AR);
    e_f2 = mk(3'd0, 2'd2, 4'd0, F_IR | F_INC);
    e_h  = mk(3'd0, 2'd0, 4'd0, F_H);
    rst = 1'b1; instruction = 8'h00; Zflag = 1'b0;
    @(posedge clk); #1;

    cyc(1'b1, 8'h00, 1'b0, EZ, "reset0");
    cyc(1'b1, 8'h00, 1'b0, EZ, "reset1");
    cyc(1'b0, 8'h00, 1'b0, EZ, "idle");
    fetch("nop");
    cyc(1'b0, 8'h00, 1'b0, EZ, "nop_dec");

    fetch("add");
    cyc(1'b0, 8'h16, 1'b0, mk(3'd1, 2'd1, 4'd0, F_Y), "add_dec");
    cyc(1'b0, 8'h16, 1'b1, mk(3'd2, 2'd0, 4'b0100, F_Z), "add_ex1");

    fetch("brz0");
    cyc(1'b0, 8'h83, 1'b0, mk(3'd0, 2'd0, 4'd0, F_INC), "brz0_dec");
    fetch("brz1");
    cyc(1'b0, 8'h83, 1'b1, mk(3'd4, 2'd1, 4'd0, F_AR), "brz1_dec");
    cyc(1'b0, 8'h83, 1'b0, mk(3'd0, 2'd2, 4'd0, F_AR), "brz1_br1");
    cyc(1'b0, 8'h83, 1'b0, mk(3'd0, 2'd2, 4'd0, F_PC), "brz1_br2");

    fetch("wr");
    cyc(1'b0, 8'h6C, 1'b0, mk(3'd4, 2'd1, 4'd0, F_AR), "wr_dec");
    cyc(1'b0, 8'h6C, 1'b0, mk(3'd0, 2'd2, 4'd0, F_AR | F_INC), "wr_wr1");
    cyc(1'b0, 8'h6C, 1'b0, mk(3'd3, 2'd0, 4'd0, F_WR), "wr_wr2");

    fetch("rd");
    cyc(1'b0, 8'h51, 1'b0, mk(3'd4, 2'd1, 4'd0, F_AR), "rd_dec");
    cyc(1'b0, 8'h51, 1'b0, mk(3'd0, 2'd2, 4'd0, F_AR | F_INC), "rd_rd1");
    cyc(1'b0, 8'h51, 1'b0, mk(3'd0, 2'd2, 4'b0010, 8'h00), "rd_rd2");

    fetch("rdrst");
    cyc(1'b0, 8'h51, 1'b0, mk(3'd4, 2'd1, 4'd0, F_AR), "rdrst_dec");
    cyc(1'b1, 8'h51, 1'b0, EZ, "rdrst_rd1");
    cyc(1'b0, 8'h51, 1'b0, EZ, "rdrst_idle");
    cyc(1'b0, 8'h51, 1'b0, e_f1, "rdrst_fet1");
    cyc(1'b0, 8'h90, 1'b0, e_f2, "ill_fet2");
    cyc(1'b0, 8'h90, 1'b0, EZ, "ill_dec");
`ifdef CU_ILLEGAL_HALT_EN
    cyc(1'b0, 8'h90, 1'b0, e_h, "ill_halt");
    cyc(1'b1, 8'h90, 1'b0, EZ, "ill_rst");
    cyc(1'b0, 8'h00, 1'b0, EZ, "ill_idle");
`else
    fetch("ill_nop");
    cyc(1'b0, 8'h00, 1'b0, EZ, "ill_nop_dec");
`endif

    fetch("halt");
    cyc(1'b0, 8'hF0, 1'b0, EZ, "halt_dec");
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'($urandom), 1'($urandom), e_h, "halt_hold");
    cyc(1'b1, 8'hF0, 1'b0, EZ, "halt_rst");
    cyc(1'b0, 8'h00, 1'b0, EZ, "halt_idle");
    fetch("post_halt");

    // Random instruction streams with occasional resets (always one first to resynchronise).
    halted_m = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 0 || $urandom_range(0, 49) == 0 || (halted_m && $urandom_range(0, 3) == 0)) begin
        cyc(1'b1, 8'($urandom), 1'($urandom), EZ, "rand_rst");
        q.delete();
        halted_m = 1'b0;
        q.push_back(mkstep(8'($urandom), 1'($urandom), EZ, 1'b0));
      end else if (halted_m) begin
        cyc(1'b0, 8'($urandom), 1'($urandom), e_h, "rand_halt");
      end else begin
        step_t s;
        if (q.size() == 0) plan();
        s = q.pop_front();
        cyc(1'b0, s.ins, s.z, s.e, "rand");
        if (s.hlt_next) halted_m = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
